// File: rtl/branch_sched.sv
// Branch resolution scheduler: evaluates MIPS-style conditional branches, waits for
// operands and the delay slot, issues one redirect per taken branch and a link write.
module branch_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic [5:0]  op,
  input  logic [4:0]  rt,
  input  logic [15:0] imm,
  input  logic [31:0] pc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        a_rdy,
  input  logic        b_rdy,
  input  logic        ds_valid,
  input  logic        redirect_ack,
  input  logic        except_flush,
  output logic        stall_id,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic [31:0] br_cnt,
  output logic [31:0] taken_cnt
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_OP, S_WAIT_DS, S_REDIR} state_t;

  state_t      r_state;
  logic [5:0]  r_op;
  logic [4:0]  r_rt;
  logic [15:0] r_imm;
  logic [31:0] r_pc;
  logic        r_taken;
  logic [31:0] r_target;
  logic        r_link_we;
  logic [31:0] r_link_data;
  logic [31:0] r_br_cnt;
  logic [31:0] r_taken_cnt;

  logic        w_in_idle;
  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [15:0] w_imm;
  logic [31:0] w_pc;
  logic        w_supported;
  logic        w_taken;
  logic        w_is_link;
  logic        w_ready;
  logic        w_cand;
  logic        w_eval;
  logic [31:0] w_target;

  // In IDLE the branch comes straight from decode; afterwards from the latched copy.
  assign w_in_idle = (r_state == S_IDLE);
  assign w_op      = w_in_idle ? op  : r_op;
  assign w_rt      = w_in_idle ? rt  : r_rt;
  assign w_imm     = w_in_idle ? imm : r_imm;
  assign w_pc      = w_in_idle ? pc  : r_pc;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_supported = 1'b0;
    w_taken     = 1'b0;
    case (w_op)
      OP_BEQ:  begin w_supported = 1'b1; w_taken = (a == b); end
      OP_BNE:  begin w_supported = 1'b1; w_taken = (a != b); end
      OP_BLEZ: begin w_supported = 1'b1; w_taken = a[31] || (a == 32'd0); end
      OP_BGTZ: begin w_supported = 1'b1; w_taken = !a[31] && (a != 32'd0); end
      OP_REGIMM: begin
        case (w_rt)
          RT_BLTZ, RT_BLTZAL: begin w_supported = 1'b1; w_taken = a[31];  end
          RT_BGEZ, RT_BGEZAL: begin w_supported = 1'b1; w_taken = !a[31]; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_is_link = (w_op == OP_REGIMM) && ((w_rt == RT_BLTZAL) || (w_rt == RT_BGEZAL));
  assign w_ready   = ((w_op == OP_BEQ) || (w_op == OP_BNE)) ? (a_rdy && b_rdy) : a_rdy;
  assign w_cand    = (w_in_idle && br_valid && w_supported) || (r_state == S_WAIT_OP);
  assign w_eval    = w_cand && w_ready && !except_flush;
  assign w_target  = w_pc + 32'd4 + {{14{w_imm[15]}}, w_imm, 2'b00};

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_rt        <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_link_we   <= 1'b0;
      r_link_data <= '0;
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_link_we <= 1'b0;
      if (except_flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (br_valid && w_supported) begin
              r_op    <= op;
              r_rt    <= rt;
              r_imm   <= imm;
              r_pc    <= pc;
              r_state <= w_ready ? S_WAIT_DS : S_WAIT_OP;
            end
          end
          S_WAIT_OP: if (w_ready) r_state <= S_WAIT_DS;
          S_WAIT_DS: if (ds_valid) r_state <= r_taken ? S_REDIR : S_IDLE;
          S_REDIR:   if (redirect_ack) r_state <= S_IDLE;
          default:   r_state <= S_IDLE;
        endcase
      end
      if (w_eval) begin
        r_taken   <= w_taken;
        r_target  <= w_target;
        r_br_cnt  <= r_br_cnt + 32'd1;
        if (w_taken) r_taken_cnt <= r_taken_cnt + 32'd1;
        r_link_we <= w_is_link;
        if (w_is_link) r_link_data <= w_pc + 32'd8;
      end
    end
  end

  // A flush landing on the link cycle still suppresses the GPR write.
  assign stall_id       = !rst && ((w_in_idle && br_valid && w_supported && !w_ready) ||
                                   (r_state == S_WAIT_OP));
  assign busy           = (r_state != S_IDLE);
  assign redirect_valid = (r_state == S_REDIR);
  assign redirect_pc    = r_target;
  assign link_we        = r_link_we && !except_flush;
  assign link_data      = r_link_data;
  assign br_cnt         = r_br_cnt;
  assign taken_cnt      = r_taken_cnt;

endmodule

// File: tb/tb_branch_sched.sv
// Directed bench for branch_sched: hand-computed vectors for each branch kind,
// operand stalls, link writes, flushes and mid-operation reset.
module tb_branch_sched;

  logic        clk = 1'b0;
  logic        rst, br_valid, a_rdy, b_rdy, ds_valid, redirect_ack, except_flush;
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [31:0] pc, a, b;
  logic        stall_id, busy, redirect_valid, link_we;
  logic [31:0] redirect_pc, link_data, br_cnt, taken_cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_sched dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .op(op), .rt(rt), .imm(imm), .pc(pc),
    .a(a), .b(b), .a_rdy(a_rdy), .b_rdy(b_rdy), .ds_valid(ds_valid),
    .redirect_ack(redirect_ack), .except_flush(except_flush),
    .stall_id(stall_id), .busy(busy), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .link_we(link_we), .link_data(link_data),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; br_valid = 1'b0; op = '0; rt = '0; imm = '0; pc = '0; a = '0; b = '0;
    a_rdy = 1'b0; b_rdy = 1'b0; ds_valid = 1'b0; redirect_ack = 1'b0; except_flush = 1'b0;
    tick(); tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%h want=0", busy); end
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%h want=0", stall_id); end
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv got=%h want=0", redirect_valid); end
    n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_rpc got=%h want=0", redirect_pc); end
    n_vec++; if (link_we !== 1'b0 || link_data !== 32'h0) begin n_err++; $display("FAIL reset_link got=%h/%h want=0/0", link_we, link_data); end
    n_vec++; if (br_cnt !== 32'h0 || taken_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", br_cnt, taken_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_beq_taken();
    br_valid = 1'b1; op = 6'b000100; a = 32'd5; b = 32'd5; a_rdy = 1'b1; b_rdy = 1'b1;
    pc = 32'h0040_0000; imm = 16'h0004;
    #1;
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL beq_stall got=%h want=0", stall_id); end
    tick();
    br_valid = 1'b0; redirect_ack = 1'b1;
    n_vec++; if (busy !== 1'b1 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_wait_ds busy/rv got=%h/%h want=1/0", busy, redirect_valid); end
    n_vec++; if (br_cnt !== 32'd1 || taken_cnt !== 32'd1) begin n_err++; $display("FAIL beq_cnt got=%0d/%0d want=1/1", br_cnt, taken_cnt); end
    tick();
    n_vec++; if (busy !== 1'b1 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_ack_ignored busy/rv got=%h/%h want=1/0", busy, redirect_valid); end
    redirect_ack = 1'b0; ds_valid = 1'b1;
    tick();
    ds_valid = 1'b0;
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0014) begin n_err++; $display("FAIL beq_redirect got=%h/%h want=1/00400014", redirect_valid, redirect_pc); end
    tick();
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0014) begin n_err++; $display("FAIL beq_redirect_hold got=%h/%h want=1/00400014", redirect_valid, redirect_pc); end
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    n_vec++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_idle busy/rv got=%h/%h want=0/0", busy, redirect_valid); end
  endtask

  task automatic test_bgtz_blez();
    br_valid = 1'b1; op = 6'b000111; a = 32'hFFFF_FFFF; a_rdy = 1'b1; b_rdy = 1'b0;
    pc = 32'h0000_1000; imm = 16'hFFFF;
    #1;
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL bgtz_ready_a_only stall got=%h want=0", stall_id); end
    tick();
    br_valid = 1'b0; ds_valid = 1'b1;
    n_vec++; if (br_cnt !== 32'd2 || taken_cnt !== 32'd1) begin n_err++; $display("FAIL bgtz_cnt got=%0d/%0d want=2/1", br_cnt, taken_cnt); end
    tick();
    ds_valid = 1'b0;
    n_vec++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL bgtz_not_taken busy/rv got=%h/%h want=0/0", busy, redirect_valid); end
    br_valid = 1'b1; op = 6'b000110;
    tick();
    br_valid = 1'b0; ds_valid = 1'b1;
    n_vec++; if (br_cnt !== 32'd3 || taken_cnt !== 32'd2) begin n_err++; $display("FAIL blez_cnt got=%0d/%0d want=3/2", br_cnt, taken_cnt); end
    tick();
    ds_valid = 1'b0;
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1000) begin n_err++; $display("FAIL blez_redirect got=%h/%h want=1/00001000", redirect_valid, redirect_pc); end
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL blez_idle busy got=%h want=0", busy); end
  endtask

  task automatic test_bne_stall();
    br_valid = 1'b1; op = 6'b000101; a = 32'd1; b = 32'd2; a_rdy = 1'b1; b_rdy = 1'b0;
    pc = 32'h0000_2000; imm = 16'h0002;
    #1;
    n_vec++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL bne_stall_c1 got=%h want=1", stall_id); end
    tick();
    op = 6'b000100; pc = 32'hDEAD_0000; imm = 16'h0100; ds_valid = 1'b1;
    #1;
    n_vec++; if (stall_id !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL bne_stall_c2 stall/busy got=%h/%h want=1/1", stall_id, busy); end
    tick();
    n_vec++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL bne_stall_c3 got=%h want=1", stall_id); end
    tick();
    ds_valid = 1'b0; b_rdy = 1'b1; a = 32'd7; b = 32'd8;
    #1;
    n_vec++; if (stall_id !== 1'b1 || br_cnt !== 32'd3) begin n_err++; $display("FAIL bne_stall_c4 stall/cnt got=%h/%0d want=1/3", stall_id, br_cnt); end
    tick();
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL bne_stall_release got=%h want=0", stall_id); end
    n_vec++; if (br_cnt !== 32'd4 || taken_cnt !== 32'd3) begin n_err++; $display("FAIL bne_cnt got=%0d/%0d want=4/3", br_cnt, taken_cnt); end
    ds_valid = 1'b1;
    tick();
    ds_valid = 1'b0;
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_200C) begin n_err++; $display("FAIL bne_redirect got=%h/%h want=1/0000200c", redirect_valid, redirect_pc); end
    br_valid = 1'b0; redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    n_vec++; if (busy !== 1'b0 || br_cnt !== 32'd4) begin n_err++; $display("FAIL bne_ignored_br busy/cnt got=%h/%0d want=0/4", busy, br_cnt); end
  endtask

  task automatic test_link();
    br_valid = 1'b1; op = 6'b000001; rt = 5'b10000; a = 32'd1; a_rdy = 1'b1; b_rdy = 1'b0;
    pc = 32'h8000_0000; imm = 16'h0010;
    tick();
    br_valid = 1'b0;
    n_vec++; if (link_we !== 1'b1 || link_data !== 32'h8000_0008) begin n_err++; $display("FAIL bltzal_link got=%h/%h want=1/80000008", link_we, link_data); end
    n_vec++; if (br_cnt !== 32'd5 || taken_cnt !== 32'd3) begin n_err++; $display("FAIL bltzal_cnt got=%0d/%0d want=5/3", br_cnt, taken_cnt); end
    ds_valid = 1'b1;
    tick();
    ds_valid = 1'b0;
    n_vec++; if (link_we !== 1'b0 || busy !== 1'b0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL bltzal_done we/busy/rv got=%h/%h/%h want=0/0/0", link_we, busy, redirect_valid); end
    br_valid = 1'b1; rt = 5'b00001; a = 32'd0; pc = 32'h0; imm = 16'h8000;
    tick();
    br_valid = 1'b0;
    n_vec++; if (link_we !== 1'b0 || taken_cnt !== 32'd4) begin n_err++; $display("FAIL bgez_nolink we/taken got=%h/%0d want=0/4", link_we, taken_cnt); end
    ds_valid = 1'b1;
    tick();
    ds_valid = 1'b0;
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hFFFE_0004) begin n_err++; $display("FAIL bgez_wrap_target got=%h/%h want=1/fffe0004", redirect_valid, redirect_pc); end
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
  endtask

  task automatic test_unsupported();
    br_valid = 1'b1; op = 6'b000010; rt = 5'b0; a_rdy = 1'b0;
    #1;
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL unsup_stall got=%h want=0", stall_id); end
    tick();
    n_vec++; if (busy !== 1'b0 || br_cnt !== 32'd6) begin n_err++; $display("FAIL unsup_op busy/cnt got=%h/%0d want=0/6", busy, br_cnt); end
    op = 6'b000001; rt = 5'b00010; a_rdy = 1'b1;
    tick();
    br_valid = 1'b0;
    n_vec++; if (busy !== 1'b0 || br_cnt !== 32'd6) begin n_err++; $display("FAIL unsup_rt busy/cnt got=%h/%0d want=0/6", busy, br_cnt); end
  endtask

  task automatic test_flush();
    br_valid = 1'b1; op = 6'b000100; a = 32'd3; b = 32'd3; a_rdy = 1'b1; b_rdy = 1'b1;
    pc = 32'h0000_3000; imm = 16'h0000;
    tick();
    br_valid = 1'b0; ds_valid = 1'b1;
    tick();
    ds_valid = 1'b0;
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_3004) begin n_err++; $display("FAIL flush_pre_redirect got=%h/%h want=1/00003004", redirect_valid, redirect_pc); end
    except_flush = 1'b1;
    tick();
    except_flush = 1'b0;
    n_vec++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL flush_redir rv/busy got=%h/%h want=0/0", redirect_valid, busy); end
    n_vec++; if (br_cnt !== 32'd7 || taken_cnt !== 32'd5) begin n_err++; $display("FAIL flush_cnt got=%0d/%0d want=7/5", br_cnt, taken_cnt); end
    tick();
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_late_redirect got=%h want=0", redirect_valid); end
    br_valid = 1'b1; op = 6'b000001; rt = 5'b10001; a = 32'd0; except_flush = 1'b1;
    tick();
    br_valid = 1'b0; except_flush = 1'b0;
    n_vec++; if (busy !== 1'b0 || br_cnt !== 32'd7 || taken_cnt !== 32'd5) begin n_err++; $display("FAIL flush_eval busy/cnt got=%h/%0d/%0d want=0/7/5", busy, br_cnt, taken_cnt); end
    n_vec++; if (link_we !== 1'b0) begin n_err++; $display("FAIL flush_eval_link_now got=%h want=0", link_we); end
    tick();
    n_vec++; if (link_we !== 1'b0) begin n_err++; $display("FAIL flush_eval_link_next got=%h want=0", link_we); end
  endtask

  task automatic test_reset_mid();
    br_valid = 1'b1; op = 6'b000100; a_rdy = 1'b0; b_rdy = 1'b1;
    tick();
    br_valid = 1'b0;
    n_vec++; if (busy !== 1'b1 || stall_id !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre busy/stall got=%h/%h want=1/1", busy, stall_id); end
    rst = 1'b1;
    tick();
    n_vec++; if (stall_id !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid stall/busy got=%h/%h want=0/0", stall_id, busy); end
    n_vec++; if (br_cnt !== 32'd0 || taken_cnt !== 32'd0) begin n_err++; $display("FAIL rst_mid_cnt got=%0d/%0d want=0/0", br_cnt, taken_cnt); end
    n_vec++; if (redirect_pc !== 32'h0 || link_data !== 32'h0) begin n_err++; $display("FAIL rst_mid_fields rpc/ld got=%h/%h want=0/0", redirect_pc, link_data); end
    rst = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_after busy got=%h want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bgtz_blez();
    test_bne_stall();
    test_link();
    test_unsupported();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
